// File: rtl/ecc_bank_responder.sv
// Bank-side codeword store for the ECC scrubber: sweeps every line to zero after reset, then serves
// 1-cycle-latency reads/writes per way. Define ECC_BANK_FAULT_INJECT_EN to add the bit-flip injection port.
module ecc_bank_responder #(
   parameter int unsigned BankSize  = 256,
   parameter int unsigned DataWidth = 39,
   parameter int unsigned ProtWidth = 7,
   parameter int unsigned Assoc     = 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [Assoc-1:0]                      req_i,
   input  logic                                  we_i,
   input  logic [$clog2(BankSize)-1:0]           add_i,
   input  logic [DataWidth-1:0]                  wdata_i,
`ifdef ECC_BANK_FAULT_INJECT_EN
   input  logic                                  inj_valid_i,
   input  logic [((Assoc > 1) ? $clog2(Assoc) : 1)-1:0] inj_way_i,
   input  logic [$clog2(BankSize)-1:0]           inj_add_i,
   input  logic [DataWidth-1:0]                  inj_mask_i,
`endif
   output logic                                  gnt_o,
   output logic [Assoc*DataWidth-1:0]            rdata_o,
   output logic [Assoc-1:0]                      rvalid_o,
   output logic                                  init_done_o
);

   localparam int unsigned AddrW = $clog2(BankSize);

   if (BankSize < 2 || (BankSize & (BankSize - 1)) != 0 || ProtWidth >= DataWidth) begin : g_param_check
      $error("ecc_bank_responder: BankSize must be a power of two >= 2 and ProtWidth < DataWidth");
   end

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_e;

   state_e                               state_q, state_d;
   logic [AddrW-1:0]                     init_add_q, init_add_d;
   logic [Assoc-1:0]                     rvalid_q, rvalid_d;
   logic [Assoc-1:0][DataWidth-1:0]      rdata_q, rdata_d;
   logic [DataWidth-1:0]                 mem_q [0:Assoc-1][0:BankSize-1];

   logic                                 ready;
   logic [Assoc-1:0]                     mem_we;
   logic [AddrW-1:0]                     mem_wadd;
   logic [DataWidth-1:0]                 mem_wdata;
   logic [Assoc-1:0]                     inj_en;

   always_comb begin
      state_d     = state_q;
      init_add_d  = init_add_q;
      ready       = (state_q == ST_READY);
      gnt_o       = ready;
      init_done_o = ready;
      unique case (state_q)
         ST_INIT: begin
            init_add_d = init_add_q + AddrW'(1);
            if (init_add_q == AddrW'(BankSize - 1)) begin
               state_d = ST_READY;
            end
         end
         ST_READY: state_d = ST_READY;
         default:  state_d = ST_INIT;
      endcase
   end

   // Init shares the single write port: every way is written at init_add_q with zero.
   always_comb begin
      mem_wadd  = ready ? add_i : init_add_q;
      mem_wdata = ready ? wdata_i : '0;
      mem_we    = '0;
      rvalid_d  = '0;
      rdata_d   = rdata_q;
      for (int unsigned w = 0; w < Assoc; w++) begin
         mem_we[w] = ready ? (req_i[w] & we_i) : 1'b1;
         if (ready && req_i[w] && !we_i) begin
            rvalid_d[w] = 1'b1;
            rdata_d[w]  = mem_q[w][add_i];
         end
      end
   end

`ifdef ECC_BANK_FAULT_INJECT_EN
   // A coincident write to the same line takes precedence; a coincident read sees the old value.
   always_comb begin
      inj_en = '0;
      for (int unsigned w = 0; w < Assoc; w++) begin
         inj_en[w] = ready && inj_valid_i
                     && (inj_way_i == ($bits(inj_way_i))'(w))
                     && !(mem_we[w] && (mem_wadd == inj_add_i));
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned w = 0; w < Assoc; w++) begin
         if (inj_en[w]) begin
            mem_q[w][inj_add_i] <= mem_q[w][inj_add_i] ^ inj_mask_i;
         end
         if (mem_we[w]) begin
            mem_q[w][mem_wadd] <= mem_wdata;
         end
      end
   end
`else
   assign inj_en = '0;

   always_ff @(posedge clk_i) begin
      for (int unsigned w = 0; w < Assoc; w++) begin
         if (mem_we[w] && !inj_en[w]) begin
            mem_q[w][mem_wadd] <= mem_wdata;
         end
      end
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_INIT;
         init_add_q <= '0;
         rvalid_q   <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         init_add_q <= init_add_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;

endmodule

// File: doc/ecc_bank_responder.md
Name: ecc_bank_responder

Overview:
- Bank-side responder for the ECC scrubber/interconnect bank interface: the block the scrubber's bank_* outputs drive, and the source of its bank_rdata_i.
- Holds Assoc ways of BankSize codewords, each DataWidth bits wide. Data bits and Hsiao parity are stored as one word.
- Serves single-cycle-issue requests with one-cycle read latency.
- After reset, self-initialises every line to the all-zero codeword, which is a valid Hsiao codeword, so scrubbing never flags uninitialised storage.

Parameters:
- BankSize, 256, lines per way; power of two, ≥2.
- DataWidth, 39, codeword width in bits (data + protection).
- ProtWidth, 7, protection bits inside the codeword. Informational only; the block never encodes or decodes.
- Assoc, 1, number of ways; all ways share address, write-enable and write data.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  Assoc  per-way request.
- we_i  in  1  1 = write, 0 = read; applies to all requested ways.
- add_i  in  $clog2(BankSize)  line address.
- wdata_i  in  DataWidth  codeword to write.
- gnt_o  out  1  high when requests are accepted; low during init.
- rdata_o  out  Assoc×DataWidth  per-way read data.
- rvalid_o  out  Assoc  per-way read-data-valid pulse.
- init_done_o  out  1  high once the init sweep has completed.

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, init_done_o=0. The internal init address is 0 and the FSM is in Init. The storage array itself has no reset.
- FSM states are Init and Ready.
- Init state:
  - Each cycle writes 0 to line init_add in every way, then increments init_add.
  - After writing line BankSize-1 (BankSize cycles total), moves to Ready. init_done_o and gnt_o rise in the first Ready cycle.
  - req_i is ignored throughout Init: no writes, no rvalid.
- Ready state:
  - gnt_o=1 and the FSM stays in Ready until reset.
  - A request is accepted when gnt_o is high and req_i[w] is high; each way is handled independently.
- Write (we_i=1):
  - mem[w][add_i] <= wdata_i at the clock edge.
  - rvalid_o[w] is 0 next cycle; rdata_o[w] holds its previous value.
- Read (we_i=0):
  - rdata_o[w] <= mem[w][add_i] and rvalid_o[w] <= 1 for exactly one cycle (latency 1).
  - Ways not requested keep their rdata_o and get rvalid_o=0.
- Hold rule: rdata_o[w] changes only on an accepted read of way w. It is stable at all other times, including across writes to the same line.
- Write followed by a read of the same line in the next cycle returns the new data; there is no bypass hazard.
- Back-to-back reads give one rvalid_o per accepted read, with no bubbles.
- Addresses are always in range; add_i is taken modulo BankSize by width.
- Reset asserted mid-init or mid-operation:
  - All outputs return to reset values immediately (asynchronously).
  - Init restarts at address 0.
  - Any in-flight read is dropped: no rvalid_o pulse follows.

Optional Feature:
- Macro: ECC_BANK_FAULT_INJECT_EN.
- When defined, the block adds these ports:
  - inj_valid_i (1)
  - inj_way_i ($clog2(Assoc), minimum 1)
  - inj_add_i ($clog2(BankSize))
  - inj_mask_i (DataWidth)
- Injection rule: in Ready, when inj_valid_i=1, mem[inj_way_i][inj_add_i] <= mem[...] XOR inj_mask_i.
- Injection with no access to that line is applied at the edge.
- Injection in the same cycle as an accepted write to the same way and line: the write wins and the injection is discarded.
- Injection in the same cycle as an accepted read of that line: the read returns the pre-flip value.
- Injection during Init is ignored.
- When the macro is not defined, the ports and logic are absent and the storage is modified only by writes and init.

Test Plan:
- Init sweep: release reset with BankSize=256 → gnt_o=0 for 256 cycles, then gnt_o=init_done_o=1; reading every line of every way returns 0 with rvalid_o pulsing once per read.
- Write then read: write 0x55_AAAA_AAAA to line 17 of way 0 in cycle t, read line 17 in cycle t+1 → rdata_o[0]=0x55_AAAA_AAAA with rvalid_o[0]=1 in cycle t+2, and rvalid_o[0]=0 in cycle t+3 with data held.
- Per-way masking: Assoc=2; write 0x1 with req_i=2'b10, then read with req_i=2'b11 → rdata_o[1]=0x1 and rdata_o[0]=0; both rvalid bits set.
- Requests during init: assert req_i=1, we_i=1, wdata_i=0x7F at cycle 5 after reset → no write occurs; after init, reading that line returns 0.
- Mid-init reset: assert rst_i at init cycle 100 → outputs go to reset values immediately; after release, init takes the full 256 cycles again.
- With ECC_BANK_FAULT_INJECT_EN: inject mask 0x1 into way 0, line 3 (holding 0) → next read returns 0x1. An injection coincident with a write of 0x10 to the same line → read returns 0x10.
